// File: rtl/reg_file_mp_if.sv
// Register file bus: read lanes, write port and pending-load scoreboard.
// The master side belongs to decode/writeback; the slave side is the register file.
interface reg_file_mp_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int READ_PORTS    = 2
);
  logic [READ_PORTS*ADDRESS_WIDTH-1:0] ra;
  logic [READ_PORTS-1:0]               ren;
  logic [READ_PORTS*WORD_WIDTH-1:0]    rd;
  logic [READ_PORTS-1:0]               rd_valid;
  logic [ADDRESS_WIDTH-1:0]            wa;
  logic [WORD_WIDTH-1:0]               wd;
  logic                                wen;
  logic                                pend_set;
  logic [ADDRESS_WIDTH-1:0]            pend_addr;
  logic [ADDRESS_WIDTH:0]              pend_cnt;

  modport master (
    output ra, ren, wa, wd, wen, pend_set, pend_addr,
    input  rd, rd_valid, pend_cnt
  );

  modport slave (
    input  ra, ren, wa, wd, wen, pend_set, pend_addr,
    output rd, rd_valid, pend_cnt
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with hardwired x0, optional write-first
// bypass and a per-register pending-load scoreboard. All outputs are registered.
module reg_file_mp #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int READ_PORTS    = 2,
  parameter int BYPASS        = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [WORD_WIDTH-1:0]    word_t;

  // NOTE: storage is built from resettable flops, not a RAM macro, because
  // reset must clear every word; mem[0] is never written so it stays zero.
  word_t                            mem [DEPTH];
  logic [DEPTH-1:0]                 pend;
  logic [ADDRESS_WIDTH:0]           cnt_q;
  logic [READ_PORTS*WORD_WIDTH-1:0] rd_q;
  logic [READ_PORTS-1:0]            valid_q;

  logic  write_hit, set_hit, set_new, clr_hit;
  addr_t lane_addr  [READ_PORTS];
  word_t lane_data  [READ_PORTS];
  logic [READ_PORTS-1:0] lane_fwd;
  logic [READ_PORTS-1:0] lane_valid;

  assign write_hit = bus.wen && (bus.wa != '0);
  assign set_hit   = bus.pend_set && (bus.pend_addr != '0);
  assign set_new   = set_hit && !pend[bus.pend_addr];
  // A write to the address being marked this cycle does not free it.
  assign clr_hit   = write_hit && pend[bus.wa] && !(set_hit && (bus.pend_addr == bus.wa));

  // NOTE: every output of this block is assigned on every path (x0 branch
  // included), so no latch is inferred for any lane.
  always_comb begin
    for (int i = 0; i < READ_PORTS; i++) begin
      lane_addr[i] = bus.ra[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      lane_fwd[i]  = (BYPASS != 0) && write_hit && (bus.wa == lane_addr[i]);
      if (lane_addr[i] == '0) begin
        lane_data[i] = '0;
      end else if (lane_fwd[i]) begin
        lane_data[i] = bus.wd;
      end else begin
        lane_data[i] = mem[lane_addr[i]];
      end
      lane_valid[i] = !(pend[lane_addr[i]] && !lane_fwd[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_hit) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      valid_q <= '1;
    end else begin
      for (int i = 0; i < READ_PORTS; i++) begin
        if (bus.ren[i]) begin
          rd_q[i*WORD_WIDTH +: WORD_WIDTH] <= lane_data[i];
          valid_q[i]                       <= lane_valid[i];
        end
      end
    end
  end

  // NOTE: non-blocking assignments make the later set override the earlier
  // clear when both target the same register in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= '0;
      cnt_q <= '0;
    end else begin
      if (write_hit) begin
        pend[bus.wa] <= 1'b0;
      end
      if (set_hit) begin
        pend[bus.pend_addr] <= 1'b1;
      end
      if (set_new && !clr_hit) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (clr_hit && !set_new) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign bus.rd       = rd_q;
  assign bus.rd_valid = valid_q;
  assign bus.pend_cnt = cnt_q;
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the RISC-V core, the successor to the two-read/one-write integer register file. It provides READ_PORTS registered read lanes, one write port, a hardwired-zero register 0, optional write-to-read bypass, and a per-register pending-write scoreboard. Decode uses the scoreboard to flag operands that a load has not yet written back. It sits between decode (read addresses, scoreboard set) and writeback (write port).

## Interface
- WORD_WIDTH, 32, data word width
- ADDRESS_WIDTH, 5, register address width; depth = 2**ADDRESS_WIDTH
- READ_PORTS, 2, number of read lanes (1..8)
- BYPASS, 1, 1 = write-first forwarding to same-cycle reads; 0 = read-first (old value)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra  in  READ_PORTS*ADDRESS_WIDTH  read addresses; lane i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- ren  in  READ_PORTS  per-lane read enable
- rd  out  READ_PORTS*WORD_WIDTH  registered read data; lane i at [i*WORD_WIDTH +: WORD_WIDTH]
- rd_valid  out  READ_PORTS  lane i data is not stale (register was not pending when read)
- wa  in  ADDRESS_WIDTH  write address
- wd  in  WORD_WIDTH  write data
- wen  in  1  write enable
- pend_set  in  1  mark register pend_addr as pending (load issued)
- pend_addr  in  ADDRESS_WIDTH  register to mark pending
- pend_cnt  out  ADDRESS_WIDTH+1  number of registers currently pending

## Operation
- Storage: 2**ADDRESS_WIDTH words. Register 0 always reads 0. Writes to register 0 are dropped. pend_set to register 0 is ignored.
- Write: when wen=1 and wa!=0, mem[wa] <= wd at the rising edge. The same write clears pend[wa].
- Read lane i, when ren[i]=1, at the rising edge:
  - rd_i <= 0 if ra_i==0.
  - Otherwise, if BYPASS=1, wen=1 and wa==ra_i: rd_i <= wd.
  - Otherwise rd_i <= mem[ra_i] (pre-edge value).
- Read lane i, when ren[i]=0: rd_i and rd_valid[i] hold.
- Any number of lanes may read the same address in one cycle. All of them return identical data.
- rd_valid[i] <= !(pend[ra_i] && !(BYPASS && wen && wa==ra_i)). Register 0 is always valid.
- Scoreboard: one pend bit per register.
  - pend_set=1 sets pend[pend_addr].
  - A write clears pend[wa].
  - pend_set and a write to the same address in one cycle: set wins, and the bit stays 1. The later-issued load owns the register.
  - pend_set on an already-pending register leaves it set. pend_cnt does not change.
- pend_cnt tracks the population of pend. It changes by -1, 0 or +1 per cycle:
  - +1 when a new bit is set.
  - -1 when a set bit is cleared.
  - 0 when a set and a clear on different addresses occur together.
- A same-cycle pend_set to address A does not affect rd_valid for a read of A in that cycle. That read precedes the load in program order.

## Timing
- Read latency: 1 cycle. The address presented in cycle N appears on rd and rd_valid after the edge ending cycle N.
- Write visible to ordinary reads from the cycle after the write edge. Also visible in the same cycle via bypass when BYPASS=1.
- Scoreboard updates are visible to rd_valid and pend_cnt from the next cycle.
- Reset (rst=1 at an edge) overrides every other input in that cycle:
  - all mem words = 0
  - all pend bits = 0
  - pend_cnt = 0
  - rd = 0
  - rd_valid = all 1
- Reset in the middle of pending loads discards all pending state. A writeback arriving after reset updates mem normally and clears an already-clear bit; pend_cnt stays 0.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Reset then reads: rst=1 for 1 cycle, then ra=x5,x31 with ren=11 -> rd=0,0; rd_valid=11; pend_cnt=0.
- Write and read-back: write x7=0xDEADBEEF, next cycle read x7 on both lanes -> both 0xDEADBEEF one cycle later. Write x0=0x1234, read x0 -> 0.
- Bypass: same cycle wen=1 wa=x9 wd=0xA5A5A5A5 and ra0=x9 (old value 0x11). BYPASS=1 -> rd0=0xA5A5A5A5 with rd_valid0=1. BYPASS=0 -> rd0=0x11.
- Scoreboard: pend_set x3, next cycle read x3 -> rd_valid=0 and pend_cnt=1. Write x3=0x55 -> pend_cnt=0. Next read of x3 -> 0x55 with rd_valid=1.
- Simultaneous set and clear: pend x4 set, then one cycle with wen wa=x4 and pend_set x4 -> pend_cnt stays 1 and a read of x4 shows rd_valid=0. Set x6 and clear x4 in one cycle -> pend_cnt stays 1.
- ren hold and mid-op reset: ren=0 with changing ra -> rd unchanged. Set x2, x8 pending (pend_cnt=2), then rst -> pend_cnt=0 and a read of x8 returns 0 with rd_valid=1.
